// File: rtl/bus_timer_periph.sv
// Memory-mapped reload timer, LED register and SysTick counter on the MEM-stage data bus.
// Optional 12-bit seven-segment register enabled by defining BUS_TIMER_DIGI_EN.
module bus_timer_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned LED_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic             Mem_rd,
  input  logic             Mem_wr,
  input  logic [31:0]      Write_data,
  output logic [31:0]      Read_data,
  output logic             irq,
  output logic [LED_W-1:0] leds,
  output logic [11:0]      digi
);

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  logic             hit;
  logic [2:0]       off;
  logic             wr_en;
  logic             ovf;
  logic             unused_addr_bits;

  logic [31:0]      th_q, th_d;
  logic [31:0]      tl_q, tl_d;
  logic [2:0]       tcon_q, tcon_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      systick_q, systick_d;

  assign hit              = (addr[31:5] == BASE_ADDR[31:5]);
  assign off              = addr[4:2];
  assign wr_en            = Mem_wr && hit;
  assign ovf              = tcon_q[0] && (tl_q == ALL_ONES);
  assign unused_addr_bits = ^addr[1:0];

  // Hardware updates first; a CPU write to the same register then overrides them.
  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    led_d     = led_q;
    systick_d = systick_q + 32'd1;
    if (tcon_q[0]) begin
      tl_d = ovf ? th_q : tl_q + 32'd1;
    end
    if (ovf && tcon_q[1]) begin
      tcon_d[2] = 1'b1;
    end
    if (wr_en) begin
      case (off)
        3'd0:    th_d      = Write_data;
        3'd1:    tl_d      = Write_data;
        3'd2:    tcon_d    = Write_data[2:0];
        3'd3:    led_d     = Write_data[LED_W-1:0];
        3'd5:    systick_d = Write_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      systick_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      systick_q <= systick_d;
    end
  end

`ifdef BUS_TIMER_DIGI_EN
  logic [11:0] digi_q, digi_d;

  always_comb begin
    digi_d = digi_q;
    if (wr_en && (off == 3'd4)) begin
      digi_d = Write_data[11:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digi_q <= '0;
    end else begin
      digi_q <= digi_d;
    end
  end

  assign digi = digi_q;
`else
  assign digi = 12'h000;
`endif

  // Zero-latency load path; returns pre-write values when a store shares the cycle.
  always_comb begin
    Read_data = '0;
    if (Mem_rd && hit) begin
      case (off)
        3'd0:    Read_data = th_q;
        3'd1:    Read_data = tl_q;
        3'd2:    Read_data = {29'd0, tcon_q};
        3'd3:    Read_data = 32'(led_q);
`ifdef BUS_TIMER_DIGI_EN
        3'd4:    Read_data = {20'd0, digi_q};
`endif
        3'd5:    Read_data = systick_q;
        default: Read_data = '0;
      endcase
    end
  end

  assign irq  = tcon_q[2];
  assign leds = led_q;

endmodule
